// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage MIPS pipeline. It produces per-register
// hold/flush controls from load-use, branch, mult/div occupancy and data-memory wait states.
module hazard_ctrl #(
    parameter int unsigned MDU_CYCLES   = 32,
    parameter int unsigned CNT_WIDTH    = 6,
    parameter int unsigned RegAddrWidth = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ReadMem_EX,
    input  logic                    WriteReg_EX,
    input  logic [RegAddrWidth-1:0] dest_EX,
    input  logic [RegAddrWidth-1:0] raddr_1_ID,
    input  logic [RegAddrWidth-1:0] raddr_2_ID,
    input  logic                    use_1_ID,
    input  logic                    use_2_ID,
    input  logic                    branch_taken_ID,
    input  logic                    mdu_start_EX,
    input  logic                    mem_req,
    input  logic                    mem_ready,
    output logic                    hold_PC,
    output logic                    hold_IF_ID,
    output logic                    hold_ID_EX,
    output logic                    hold_EX_MEM,
    output logic                    flush_IF_ID,
    output logic                    flush_ID_EX,
    output logic                    flush_EX_MEM,
    output logic                    flush_MEM_WB,
    output logic                    mdu_done,
    output logic [31:0]             stall_cycles
);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MDU_CYCLES - 1);

    mdu_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          stall_cycles_q, stall_cycles_d;

    logic ms;
    logic lu;
    logic md;

    always_comb begin
        ms = mem_req & ~mem_ready;
        lu = ReadMem_EX & WriteReg_EX & (dest_EX != '0) &
             ((use_1_ID & (dest_EX == raddr_1_ID)) |
              (use_2_ID & (dest_EX == raddr_2_ID)));
        md = ((state_q == RUN) & mdu_start_EX) |
             ((state_q == BUSY) & (cnt_q != '0));
    end

    // MDU occupancy: the counter keeps running under a memory stall, but completion waits for it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mdu_done = 1'b0;
        case (state_q)
            RUN: begin
                if (mdu_start_EX && !ms) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!ms) begin
                    mdu_done = ~rst;
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        hold_PC      = 1'b0;
        hold_IF_ID   = 1'b0;
        hold_ID_EX   = 1'b0;
        hold_EX_MEM  = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        flush_MEM_WB = 1'b0;
        if (rst) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            flush_MEM_WB = 1'b1;
        end else if (ms) begin
            hold_PC      = 1'b1;
            hold_IF_ID   = 1'b1;
            hold_ID_EX   = 1'b1;
            hold_EX_MEM  = 1'b1;
            flush_MEM_WB = 1'b1;
        end else if (md) begin
            hold_PC      = 1'b1;
            hold_IF_ID   = 1'b1;
            hold_ID_EX   = 1'b1;
            flush_EX_MEM = 1'b1;
        end else if (lu) begin
            hold_PC     = 1'b1;
            hold_IF_ID  = 1'b1;
            flush_ID_EX = 1'b1;
        end else if (branch_taken_ID) begin
            flush_IF_ID = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, hold_PC};
        stall_cycles   = stall_cycles_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MDU_CYCLES=4: a combinational vector table plus
// hand-written MDU, memory-wait, reset and counter-wrap sequences.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ReadMem_EX, WriteReg_EX;
    logic [4:0] dest_EX, raddr_1_ID, raddr_2_ID;
    logic       use_1_ID, use_2_ID, branch_taken_ID, mdu_start_EX, mem_req, mem_ready;
    logic       hold_PC, hold_IF_ID, hold_ID_EX, hold_EX_MEM;
    logic       flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, mdu_done;
    logic [31:0] stall_cycles;

    hazard_ctrl #(.MDU_CYCLES(4), .CNT_WIDTH(6), .RegAddrWidth(5)) dut (
        .clk(clk), .rst(rst),
        .ReadMem_EX(ReadMem_EX), .WriteReg_EX(WriteReg_EX), .dest_EX(dest_EX),
        .raddr_1_ID(raddr_1_ID), .raddr_2_ID(raddr_2_ID),
        .use_1_ID(use_1_ID), .use_2_ID(use_2_ID),
        .branch_taken_ID(branch_taken_ID), .mdu_start_EX(mdu_start_EX),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .hold_PC(hold_PC), .hold_IF_ID(hold_IF_ID), .hold_ID_EX(hold_ID_EX),
        .hold_EX_MEM(hold_EX_MEM), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
        .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
        .mdu_done(mdu_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // {hPC, hIF_ID, hID_EX, hEX_MEM, fIF_ID, fID_EX, fEX_MEM, fMEM_WB, mdu_done}
    localparam logic [8:0] O_NONE = 9'b0000_0000_0;
    localparam logic [8:0] O_LU   = 9'b1100_0100_0;
    localparam logic [8:0] O_BR   = 9'b0000_1000_0;
    localparam logic [8:0] O_MS   = 9'b1111_0001_0;
    localparam logic [8:0] O_MD   = 9'b1110_0010_0;
    localparam logic [8:0] O_DONE = 9'b0000_0000_1;
    localparam logic [8:0] O_RST  = 9'b0000_1111_0;

    typedef struct {
        logic       rm, wr;
        logic [4:0] dest, r1, r2;
        logic       u1, u2, br, mreq, mrdy;
        logic [8:0] exp;
    } vec_t;

    vec_t        vecs[13];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic [31:0] exp_stall;
    int unsigned done_cnt;

    logic [8:0] out_v;
    assign out_v = {hold_PC, hold_IF_ID, hold_ID_EX, hold_EX_MEM,
                    flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, mdu_done};

    task automatic idle_inputs();
        ReadMem_EX = 0; WriteReg_EX = 0; dest_EX = 0; raddr_1_ID = 0; raddr_2_ID = 0;
        use_1_ID = 0; use_2_ID = 0; branch_taken_ID = 0; mdu_start_EX = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    // Inputs are already driven at the falling edge; sample, check, then advance one cycle.
    task automatic step(input string name, input logic [8:0] exp);
        #1;
        n_cmp++;
        if (out_v !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs got %b want %b", name, out_v, exp);
        end
        n_cmp++;
        if (stall_cycles !== exp_stall) begin
            n_fail++;
            $display("FAIL %s: stall_cycles got %0d want %0d", name, stall_cycles, exp_stall);
        end
        if (mdu_done === 1'b1) done_cnt++;
        if (!rst) exp_stall = exp_stall + {31'd0, exp[8]};
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_NONE};
        vecs[1]  = '{1, 1, 5'd2, 5'd2, 5'd7, 1, 0, 0, 0, 0, O_LU};
        vecs[2]  = '{1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, O_NONE};
        vecs[3]  = '{1, 1, 5'd2, 5'd2, 5'd7, 0, 0, 0, 0, 0, O_NONE};
        vecs[4]  = '{1, 1, 5'd9, 5'd3, 5'd9, 1, 1, 0, 0, 0, O_LU};
        vecs[5]  = '{1, 1, 5'd9, 5'd9, 5'd9, 0, 0, 0, 0, 0, O_NONE};
        vecs[6]  = '{1, 0, 5'd2, 5'd2, 5'd2, 1, 1, 0, 0, 0, O_NONE};
        vecs[7]  = '{0, 1, 5'd2, 5'd2, 5'd2, 1, 1, 0, 0, 0, O_NONE};
        vecs[8]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, O_BR};
        vecs[9]  = '{1, 1, 5'd2, 5'd2, 5'd0, 1, 0, 1, 0, 0, O_LU};
        vecs[10] = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, O_MS};
        vecs[11] = '{1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 1, O_LU};
        vecs[12] = '{1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 0, O_MS};

        idle_inputs();
        exp_stall = 0;
        done_cnt  = 0;
        rst = 1;
        @(negedge clk);
        step("reset_outputs", O_RST);
        rst = 0;
        exp_stall = 0;

        for (int i = 0; i < 13; i++) begin
            ReadMem_EX = vecs[i].rm;  WriteReg_EX = vecs[i].wr; dest_EX = vecs[i].dest;
            raddr_1_ID = vecs[i].r1;  raddr_2_ID = vecs[i].r2;
            use_1_ID = vecs[i].u1;    use_2_ID = vecs[i].u2;
            branch_taken_ID = vecs[i].br; mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
            step($sformatf("vec%0d", i), vecs[i].exp);
        end
        idle_inputs();

        // MDU, start held through T4, released at T5
        done_cnt = 0;
        mdu_start_EX = 1;
        for (int t = 0; t < 4; t++) step($sformatf("mdu_T%0d", t), O_MD);
        step("mdu_T4_done", O_DONE);
        mdu_start_EX = 0;
        step("mdu_T5_run", O_NONE);
        n_cmp++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL mdu_done_count: got %0d want 1", done_cnt);
        end

        // MDU with memory stall during T3..T6
        done_cnt = 0;
        mdu_start_EX = 1;
        for (int t = 0; t < 3; t++) step($sformatf("mdums_T%0d", t), O_MD);
        mem_req = 1; mem_ready = 0;
        for (int t = 3; t < 7; t++) step($sformatf("mdums_T%0d", t), O_MS);
        mem_req = 0;
        step("mdums_T7_done", O_DONE);
        mdu_start_EX = 0;
        step("mdums_T8", O_NONE);
        step("mdums_T9", O_NONE);
        n_cmp++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL mdums_done_count: got %0d want 1", done_cnt);
        end

        // Memory wait: three wait cycles, then ready
        mem_req = 1; mem_ready = 0;
        for (int t = 0; t < 3; t++) step($sformatf("memwait_%0d", t), O_MS);
        mem_ready = 1;
        step("memwait_ready", O_NONE);
        idle_inputs();

        // Reset at T2 of an MDU operation abandons it
        mdu_start_EX = 1;
        step("rstmdu_T0", O_MD);
        step("rstmdu_T1", O_MD);
        rst = 1;
        step("rstmdu_T2_rst", O_RST);
        rst = 0;
        exp_stall = 0;
        mdu_start_EX = 0;
        step("rstmdu_after", O_NONE);
        mdu_start_EX = 1;
        for (int t = 0; t < 4; t++) step($sformatf("rstmdu_new_T%0d", t), O_MD);
        step("rstmdu_new_done", O_DONE);
        mdu_start_EX = 0;

        // Counter wrap
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        exp_stall = 32'hFFFF_FFFF;
        mem_req = 1; mem_ready = 0;
        step("wrap_stall", O_MS);
        idle_inputs();
        step("wrap_zero", O_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
